// File: rtl/sa_tile_engine.sv
// sa_tile_engine: weight-stationary ROWS x COLS systolic tile.
// Weights are loaded one row per beat. Activation vectors enter skewed by row,
// flow east through the PEs while partial sums flow south, and are deskewed per
// column. Each result appears ROWS+COLS cycles after its vector was accepted.
// Build option: define SA_TILE_SAT_EN to make every PE add saturate instead of wrap.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for i_start (ignored during the o_done cycle)
// S_LOAD    | accepting ROWS weight beats, beat k goes to PE row k
// S_COMPUTE | accepting activation vectors until the latched length is reached
// S_DRAIN   | down-counting ROWS+COLS cycles so in-flight results leave the array
module sa_tile_engine #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [15:0]              i_len,
  input  logic                     i_w_valid,
  input  logic [COLS*DATA_W-1:0]   i_w_data,
  output logic                     o_w_ready,
  input  logic                     i_x_valid,
  input  logic [ROWS*DATA_W-1:0]   i_x_data,
  output logic                     o_x_ready,
  output logic                     o_y_valid,
  output logic [COLS*ACC_W-1:0]    o_y_data,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int LAT = ROWS + COLS;
  localparam int WCW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DCW = $clog2(LAT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      len_q, len_d;
  logic [WCW-1:0]   w_cnt_q, w_cnt_d;
  logic [15:0]      x_cnt_q, x_cnt_d;
  logic [DCW-1:0]   dr_cnt_q, dr_cnt_d;
  logic             w_ready_q, w_ready_d;
  logic             x_ready_q, x_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             w_acc;
  logic             x_acc;

  logic [DATA_W-1:0] w_q  [ROWS][COLS];
  logic [DATA_W-1:0] w_d  [ROWS][COLS];
  logic [DATA_W-1:0] sk_q [ROWS][ROWS];
  logic [DATA_W-1:0] sk_d [ROWS][ROWS];
  logic [DATA_W-1:0] a_q  [ROWS][COLS];
  logic [DATA_W-1:0] a_d  [ROWS][COLS];
  logic [ACC_W-1:0]  ps_q [ROWS][COLS];
  logic [ACC_W-1:0]  ps_d [ROWS][COLS];
  logic [ACC_W-1:0]  dq_q [COLS][COLS];
  logic [ACC_W-1:0]  dq_d [COLS][COLS];
  logic [DATA_W-1:0] ain  [ROWS][COLS];
  logic [ACC_W-1:0]  pn   [ROWS][COLS];
  logic [LAT-1:0]    vp_q, vp_d;
  logic              y_valid_q, y_valid_d;

  assign w_acc = w_ready_q & i_w_valid;
  assign x_acc = x_ready_q & i_x_valid;

  // One PE step: signed product sign-extended to ACC_W and added to the north sum.
  function automatic logic [ACC_W-1:0] mac(input logic [ACC_W-1:0]  psum,
                                           input logic [DATA_W-1:0] act,
                                           input logic [DATA_W-1:0] wgt);
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
`ifdef SA_TILE_SAT_EN
    logic signed [ACC_W:0]      sum_w;
`endif
    prod     = (2*DATA_W)'($signed(act)) * (2*DATA_W)'($signed(wgt));
    prod_ext = ACC_W'(prod);
`ifdef SA_TILE_SAT_EN
    sum_w = (ACC_W+1)'($signed(psum)) + (ACC_W+1)'(prod_ext);
    if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
      mac = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      mac = sum_w[ACC_W-1:0];
    end
`else
    mac = psum + prod_ext;
`endif
  endfunction

  // Next-state, counters and registered handshake/status outputs.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    w_cnt_d  = w_cnt_q;
    x_cnt_d  = x_cnt_q;
    dr_cnt_d = dr_cnt_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // o_done is high only in the first IDLE cycle; a start there is dropped
        if (i_start && !done_q) begin
          state_d = S_LOAD;
          len_d   = i_len;
          w_cnt_d = '0;
          x_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (w_acc) begin
          if (w_cnt_q == WCW'(ROWS-1)) begin
            if (len_q != 16'd0) begin
              state_d = S_COMPUTE;
            end else begin
              state_d  = S_DRAIN;
              dr_cnt_d = DCW'(LAT-1);
            end
          end else begin
            w_cnt_d = w_cnt_q + 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        if (x_acc) begin
          x_cnt_d = x_cnt_q + 16'd1;
          if (x_cnt_d == len_q) begin
            state_d  = S_DRAIN;
            dr_cnt_d = DCW'(LAT-1);
          end
        end
      end
      S_DRAIN: begin
        if (dr_cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          dr_cnt_d = dr_cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    w_ready_d = (state_d == S_LOAD);
    x_ready_d = (state_d == S_COMPUTE) && (x_cnt_d < len_d);
    busy_d    = (state_d != S_IDLE);
  end

  // Control register update with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      w_cnt_q   <= '0;
      x_cnt_q   <= '0;
      dr_cnt_q  <= '0;
      w_ready_q <= 1'b0;
      x_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      w_cnt_q   <= w_cnt_d;
      x_cnt_q   <= x_cnt_d;
      dr_cnt_q  <= dr_cnt_d;
      w_ready_q <= w_ready_d;
      x_ready_q <= x_ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Weight write, input skew, PE mesh, output deskew and valid pipeline.
  always_comb begin
    w_d  = w_q;
    sk_d = sk_q;
    a_d  = a_q;
    ps_d = ps_q;
    dq_d = dq_q;
    ain  = '{default: '0};
    pn   = '{default: '0};
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        if (w_acc && (w_cnt_q == WCW'(i))) begin
          w_d[i][j] = i_w_data[(COLS-1-j)*DATA_W +: DATA_W];
        end
      end
    end
    // Bubbles enter as zero activations; the valid pipe marks them invalid.
    for (int i = 0; i < ROWS; i++) begin
      sk_d[i][0] = x_acc ? i_x_data[(ROWS-1-i)*DATA_W +: DATA_W] : '0;
      for (int k = 1; k < ROWS; k++) begin
        sk_d[i][k] = sk_q[i][k-1];
      end
    end
    for (int i = 0; i < ROWS; i++) begin
      ain[i][0] = sk_q[i][i];
      for (int j = 1; j < COLS; j++) begin
        ain[i][j] = a_q[i][j-1];
      end
    end
    for (int j = 0; j < COLS; j++) begin
      pn[0][j] = '0;
      for (int i = 1; i < ROWS; i++) begin
        pn[i][j] = ps_q[i-1][j];
      end
    end
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        a_d[i][j]  = ain[i][j];
        ps_d[i][j] = mac(pn[i][j], ain[i][j], w_q[i][j]);
      end
    end
    // Column j waits COLS-1-j extra cycles; its last stage doubles as the
    // output register and is zeroed when no valid result lands there.
    for (int j = 0; j < COLS; j++) begin
      dq_d[j][0] = ps_q[ROWS-1][j];
      for (int k = 1; k < COLS; k++) begin
        dq_d[j][k] = dq_q[j][k-1];
      end
      dq_d[j][COLS-1-j] = vp_q[LAT-1] ? dq_d[j][COLS-1-j] : '0;
    end
    vp_d      = {vp_q[LAT-2:0], x_acc};
    y_valid_d = vp_q[LAT-1];
  end

  // Datapath register update with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      w_q       <= '{default: '0};
      sk_q      <= '{default: '0};
      a_q       <= '{default: '0};
      ps_q      <= '{default: '0};
      dq_q      <= '{default: '0};
      vp_q      <= '0;
      y_valid_q <= 1'b0;
    end else begin
      w_q       <= w_d;
      sk_q      <= sk_d;
      a_q       <= a_d;
      ps_q      <= ps_d;
      dq_q      <= dq_d;
      vp_q      <= vp_d;
      y_valid_q <= y_valid_d;
    end
  end

  // Result vector gathered from the final deskew stage of each column.
  always_comb begin
    o_y_data = '0;
    for (int j = 0; j < COLS; j++) begin
      o_y_data[(COLS-1-j)*ACC_W +: ACC_W] = dq_q[j][COLS-1-j];
    end
  end

  assign o_w_ready = w_ready_q;
  assign o_x_ready = x_ready_q;
  assign o_y_valid = y_valid_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_sa_tile_engine.sv
// Directed bench for sa_tile_engine: a 32-bit accumulator instance plus a
// 16-bit accumulator instance sharing the same stimulus. Honours SA_TILE_SAT_EN.
module tb_sa_tile_engine;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_start;
  logic [15:0]  i_len;
  logic         i_w_valid;
  logic [31:0]  i_w_data;
  logic         i_x_valid;
  logic [31:0]  i_x_data;

  logic         o_w_ready, o_x_ready, o_y_valid, o_busy, o_done;
  logic [127:0] o_y_data;
  logic         w_ready16, x_ready16, y_valid16, busy16, done16;
  logic [63:0]  y_data16;

  int n_chk = 0;
  int n_err = 0;

  logic xr_seen, yv_seen, done_seen, busy_seen;

`ifdef SA_TILE_SAT_EN
  localparam logic [63:0] SAT16_EXP = 64'h7FFF_7FFF_7FFF_7FFF;
`else
  localparam logic [63:0] SAT16_EXP = 64'h0;
`endif

  sa_tile_engine #(.ROWS(4), .COLS(4), .DATA_W(8), .ACC_W(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_len(i_len),
    .i_w_valid(i_w_valid), .i_w_data(i_w_data), .o_w_ready(o_w_ready),
    .i_x_valid(i_x_valid), .i_x_data(i_x_data), .o_x_ready(o_x_ready),
    .o_y_valid(o_y_valid), .o_y_data(o_y_data), .o_busy(o_busy), .o_done(o_done)
  );

  sa_tile_engine #(.ROWS(4), .COLS(4), .DATA_W(8), .ACC_W(16)) dut16 (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_len(i_len),
    .i_w_valid(i_w_valid), .i_w_data(i_w_data), .o_w_ready(w_ready16),
    .i_x_valid(i_x_valid), .i_x_data(i_x_data), .o_x_ready(x_ready16),
    .o_y_valid(y_valid16), .o_y_data(y_data16), .o_busy(busy16), .o_done(done16)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [15:0] len);
    i_start = 1'b1;
    i_len   = len;
    tick();
    i_start = 1'b0;
  endtask

  task automatic load_rows(input logic [31:0] r0, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [31:0] r3);
    logic [31:0] rows [4];
    rows = '{r0, r1, r2, r3};
    for (int k = 0; k < 4; k++) begin
      i_w_valid = 1'b1;
      i_w_data  = rows[k];
      tick();
    end
    i_w_valid = 1'b0;
    i_w_data  = '0;
  endtask

  task automatic send_x(input logic [31:0] x);
    i_x_valid = 1'b1;
    i_x_data  = x;
    tick();
    i_x_valid = 1'b0;
    i_x_data  = '0;
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_len = '0;
    i_w_valid = 1'b0; i_w_data = '0; i_x_valid = 1'b0; i_x_data = '0;
    tick(); tick();
    chk1("rst_busy", o_busy, 1'b0);
    chk1("rst_w_ready", o_w_ready, 1'b0);
    chk1("rst_x_ready", o_x_ready, 1'b0);
    chk1("rst_y_valid", o_y_valid, 1'b0);
    chk1("rst_done", o_done, 1'b0);
    chk128("rst_y_data", o_y_data, 128'h0);
    chk1("rst_ctrl16", w_ready16 | x_ready16 | busy16 | done16 | y_valid16, 1'b0);
    i_rst = 1'b0;
    tick();

    // identity weights, one vector
    start_job(16'd1);
    chk1("t1_w_ready", o_w_ready, 1'b1);
    chk1("t1_busy", o_busy, 1'b1);
    load_rows(32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001);
    chk1("t1_w_ready_off", o_w_ready, 1'b0);
    chk1("t1_x_ready", o_x_ready, 1'b1);
    send_x(32'h01020304);
    chk1("t1_x_ready_off", o_x_ready, 1'b0);
    repeat (7) tick();
    chk1("t1_y_early", o_y_valid, 1'b0);
    chk1("t1_done_early", o_done, 1'b0);
    tick();
    chk1("t1_y_valid", o_y_valid, 1'b1);
    chk128("t1_y_data", o_y_data, 128'h00000001_00000002_00000003_00000004);
    chk1("t1_done", o_done, 1'b1);
    tick();
    chk1("t1_y_valid_off", o_y_valid, 1'b0);
    chk128("t1_y_zero", o_y_data, 128'h0);
    chk1("t1_idle", o_busy, 1'b0);

    // all weights -1, activations 127
    start_job(16'd1);
    load_rows(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    send_x(32'h7F7F7F7F);
    repeat (7) tick();
    tick();
    chk1("t2_y_valid", o_y_valid, 1'b1);
    chk128("t2_y_data", o_y_data, 128'hFFFFFE04_FFFFFE04_FFFFFE04_FFFFFE04);
    chk64("t2_y_data16", y_data16, 64'hFE04_FE04_FE04_FE04);
    tick();

    // mixed weights, three vectors with a bubble after the first
    start_job(16'd3);
    load_rows(32'h010200FF, 32'h00010302, 32'h02000101, 32'hFF010002);
    send_x(32'h01020304);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    send_x(32'hFE000501);
    send_x(32'h0AFD00F9);
    chk1("t3_x_ready_off", o_x_ready, 1'b0);
    repeat (4) tick();
    chk1("t3_y_early", o_y_valid, 1'b0);
    tick();
    chk1("t3_ya_valid", o_y_valid, 1'b1);
    chk128("t3_ya", o_y_data, 128'h00000003_00000008_00000009_0000000E);
    tick();
    chk1("t3_gap_valid", o_y_valid, 1'b0);
    chk128("t3_gap_data", o_y_data, 128'h0);
    tick();
    chk1("t3_yb_valid", o_y_valid, 1'b1);
    chk128("t3_yb", o_y_data, 128'h00000007_FFFFFFFD_00000005_00000009);
    tick();
    chk1("t3_yc_valid", o_y_valid, 1'b1);
    chk128("t3_yc", o_y_data, 128'h00000011_0000000A_FFFFFFF7_FFFFFFE2);
    chk1("t3_done", o_done, 1'b1);
    tick();
    chk1("t3_idle", o_busy, 1'b0);

    // overflow of a 16-bit accumulator: -128 * -128 summed over four rows
    start_job(16'd1);
    load_rows(32'h80808080, 32'h80808080, 32'h80808080, 32'h80808080);
    send_x(32'h80808080);
    repeat (8) tick();
    chk1("t4_y_valid", o_y_valid, 1'b1);
    chk128("t4_y_data32", o_y_data, 128'h00010000_00010000_00010000_00010000);
    chk1("t4_y_valid16", y_valid16, 1'b1);
    chk64("t4_y_data16", y_data16, SAT16_EXP);
    tick();

    // zero-length job, then a start in the o_done cycle
    start_job(16'd0);
    chk1("t5_w_ready", o_w_ready, 1'b1);
    load_rows(32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001);
    chk1("t5_w_ready_off", o_w_ready, 1'b0);
    chk1("t5_x_ready", o_x_ready, 1'b0);
    chk1("t5_busy", o_busy, 1'b1);
    xr_seen = 1'b0; yv_seen = 1'b0; done_seen = 1'b0;
    repeat (7) begin
      tick();
      xr_seen   = xr_seen | o_x_ready;
      yv_seen   = yv_seen | o_y_valid;
      done_seen = done_seen | o_done;
    end
    chk1("t5_done_early", done_seen, 1'b0);
    tick();
    chk1("t5_done", o_done, 1'b1);
    chk1("t5_x_ready_never", xr_seen, 1'b0);
    chk1("t5_y_valid_never", yv_seen, 1'b0);
    i_start = 1'b1;
    i_len   = 16'd5;
    tick();
    i_start = 1'b0;
    chk1("t5_start_in_done_busy", o_busy, 1'b0);
    chk1("t5_start_in_done_w_ready", o_w_ready, 1'b0);

    // reset in the middle of COMPUTE, with other inputs active
    start_job(16'd2);
    load_rows(32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001);
    i_x_valid = 1'b1;
    i_x_data  = 32'h01020304;
    tick();
    i_rst   = 1'b1;
    i_start = 1'b1;
    tick();
    chk1("t6_busy", o_busy, 1'b0);
    chk1("t6_w_ready", o_w_ready, 1'b0);
    chk1("t6_x_ready", o_x_ready, 1'b0);
    chk1("t6_y_valid", o_y_valid, 1'b0);
    chk1("t6_done", o_done, 1'b0);
    chk128("t6_y_data", o_y_data, 128'h0);
    i_rst = 1'b0; i_start = 1'b0; i_x_valid = 1'b0; i_x_data = '0;
    yv_seen = 1'b0; xr_seen = 1'b0; busy_seen = 1'b0;
    repeat (12) begin
      tick();
      yv_seen   = yv_seen | o_y_valid;
      xr_seen   = xr_seen | o_x_ready;
      busy_seen = busy_seen | o_busy;
    end
    chk1("t6_no_stale_y", yv_seen, 1'b0);
    chk1("t6_no_x_ready", xr_seen, 1'b0);
    chk1("t6_stays_idle", busy_seen, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sa_tile_engine.md
SA_TILE_ENGINE -- requirements
Module: sa_tile_engine

Interface
REQ-001 SHALL have parameter ROWS, default 4: PE rows and input-vector length.
REQ-002 SHALL have parameter COLS, default 4: PE columns and output-vector length.
REQ-003 SHALL have parameter DATA_W, default 8: signed weight and activation width.
REQ-004 SHALL have parameter ACC_W, default 32: signed accumulator width; ACC_W >= 2*DATA_W+clog2(ROWS).
REQ-005 SHALL have port i_clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_start  input  1  start pulse; sampled only in IDLE.
REQ-008 SHALL have port i_len  input  16  number of activation vectors per job; latched on accepted i_start.
REQ-009 SHALL have port i_w_valid  input  1  weight beat valid.
REQ-010 SHALL have port i_w_data  input  COLS*DATA_W  one weight row; column 0 in MSBs.
REQ-011 SHALL have port o_w_ready  output  1  weight beat accepted when valid&ready.
REQ-012 SHALL have port i_x_valid  input  1  activation vector valid.
REQ-013 SHALL have port i_x_data  input  ROWS*DATA_W  activation vector; row 0 in MSBs.
REQ-014 SHALL have port o_x_ready  output  1  activation accepted when valid&ready.
REQ-015 SHALL have port o_y_valid  output  1  result vector valid; no output backpressure.
REQ-016 SHALL have port o_y_data  output  COLS*ACC_W  result vector; column 0 in MSBs.
REQ-017 SHALL have ports o_busy and o_done, output, 1 bit each: busy level (not IDLE); done single-cycle pulse.

Function
REQ-018 SHALL be a weight-stationary ROWS x COLS systolic array computing y[j] = sum over i of x[i]*W[i][j].
REQ-019 SHALL implement FSM states IDLE, LOAD, COMPUTE, DRAIN.
REQ-020 SHALL move IDLE->LOAD on i_start, latching i_len and clearing the weight-beat and vector counters.
REQ-021 SHALL assert o_w_ready only in LOAD; accepted beat k (k = 0..ROWS-1) is written into PE row k.
REQ-022 SHALL leave LOAD after beat ROWS-1: to COMPUTE if latched length > 0, else to DRAIN.
REQ-023 SHALL assert o_x_ready in COMPUTE while accepted count < latched length; go to DRAIN after the last accept.
REQ-024 SHALL skew row i input by i cycles, register every PE output, and deskew column j output by COLS-1-j cycles.
REQ-025 SHALL present o_y_valid/o_y_data exactly ROWS+COLS cycles after the accepting edge of its x vector, in order, one result per accepted vector.
REQ-026 SHALL carry x-side bubbles (i_x_valid low) through the pipeline as o_y_valid low with identical latency.
REQ-027 SHALL stay in DRAIN ROWS+COLS cycles, then pulse o_done for one cycle while returning to IDLE.
REQ-028 SHALL form each product as signed 2*DATA_W, sign-extend it to ACC_W, and add it to the north partial sum (row 0 north = 0), wrapping modulo 2^ACC_W.
REQ-029 SHALL ignore i_start outside IDLE; i_start in the same cycle as o_done is ignored.
REQ-030 SHALL retain weights after a job; a new job always reloads all ROWS rows.
REQ-031 SHALL drive o_y_data to 0 whenever o_y_valid is low.

Reset
REQ-032 SHALL, on i_rst high at any clock edge including mid-job, enter IDLE; clear weights, skew/deskew registers, pipeline valids and counters; drive all outputs to 0.
REQ-033 SHALL give i_rst priority over every other input in the same cycle.

Configuration
REQ-034 SHALL, with SA_TILE_SAT_EN defined, saturate each PE addition to [-2^(ACC_W-1), 2^(ACC_W-1)-1] instead of wrapping.
REQ-035 SHALL, without SA_TILE_SAT_EN, use wrap-around arithmetic (REQ-028) with no saturation logic present.

Verification
REQ-036 SHALL cover: 4x4 identity W, len=1, x=[1,2,3,4] -> y=[1,2,3,4] valid 8 cycles after accept, o_done 8 cycles after DRAIN entry.
REQ-037 SHALL cover: all W=-1, x all 127 -> every y[j]=-508.
REQ-038 SHALL cover: len=3 with one i_x_valid-low cycle between vectors 1 and 2 -> three results, one o_y_valid gap in the same position.
REQ-039 SHALL cover: ACC_W=16, all W=-128, all x=-128 -> y=32767 with SA_TILE_SAT_EN, y=0 without.
REQ-040 SHALL cover: len=0 -> LOAD accepts 4 beats, o_x_ready never high, o_done after 8 DRAIN cycles.
REQ-041 SHALL cover: i_rst pulsed mid-COMPUTE -> next cycle IDLE, all outputs 0, no stale o_y_valid afterwards.
